// File: rtl/protocol_pkg.sv
// Shared definitions for the controller link: command codes, default
// field widths and the decoder state encoding.
package protocol_pkg;

    // Command codes carried in the message header
    localparam int CMD_KEYFRAME = 0;

    // Default header / keyframe field widths (bits)
    localparam int DEF_CMD_W  = 5;
    localparam int DEF_LEN_W  = 11;
    localparam int DEF_TYPE_W = 6;
    localparam int DEF_TIME_W = 10;

    // Decoder FSM states
    typedef enum logic [2:0] {
        S_CMD     = 3'd0,
        S_LEN     = 3'd1,
        S_KF_TYPE = 3'd2,
        S_KF_DUR  = 3'd3,
        S_KF_DATA = 3'd4,
        S_SKIP    = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_sync.sv
// Brings the asynchronous DCK/CS/MOSI link into the i_clk domain.
// Each line passes a 2-flop synchroniser; one further aligned stage
// produces the DCK rising-edge bit strobe together with matching cs and
// mosi, so a strobe and the data bit / chip select it belongs to always
// appear in the same cycle.
module serial_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_dck,
    input  logic i_cs,
    input  logic i_mosi,
    output logic cs,
    output logic mosi,
    output logic bit_strobe
);

    logic [1:0] dck_s;
    logic [1:0] cs_s;
    logic [1:0] mosi_s;
    logic       dck_prev;

    // Synchronise all three lines, then detect DCK rise and align cs/mosi with it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dck_s      <= 2'b00;
            cs_s       <= 2'b11;
            mosi_s     <= 2'b00;
            dck_prev   <= 1'b0;
            cs         <= 1'b1;
            mosi       <= 1'b0;
            bit_strobe <= 1'b0;
        end else begin
            dck_s      <= {dck_s[0], i_dck};
            cs_s       <= {cs_s[0], i_cs};
            mosi_s     <= {mosi_s[0], i_mosi};
            dck_prev   <= dck_s[1];
            bit_strobe <= dck_s[1] & ~dck_prev;
            cs         <= cs_s[1];
            mosi       <= mosi_s[1];
        end
    end

endmodule

// File: rtl/frame_decoder.sv
// Serial command decoder for the LED lamp. Parses byte-framed messages
// (command, byte length, payload) arriving MSB-first on the DCK/CS/MOSI
// link and turns KEYFRAME payloads into keyframe-buffer writes. Several
// messages may share one CS window; unknown commands are skipped by
// length. Overflowing words, too-short keyframes and CS aborts raise a
// one-cycle o_err.
//
// Handshake: there is no backpressure. o_wen is a one-cycle strobe;
// o_addr/o_data are valid exactly while o_wen is high, and o_addr steps
// to the next address in the cycle after the strobe.
module frame_decoder
    import protocol_pkg::*;
#(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_cmd_w     = DEF_CMD_W,
    parameter int c_len_w     = DEF_LEN_W,
    parameter int c_time_w    = DEF_TIME_W,
    parameter int c_type_w    = DEF_TYPE_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_dck,
    input  logic                i_cs,
    input  logic                i_mosi,
    output logic                o_wen,
    output logic [c_addr_w-1:0] o_addr,
    output logic [c_bpc-1:0]    o_data,
    output logic [c_time_w-1:0] o_time,
    output logic [c_type_w-1:0] o_type,
    output logic                o_kf_done,
    output logic                o_err,
    output state_t              o_dbg_state
);

    // Widest field decides the shift register width; counter covers it
    localparam int c_sr_w  = max_int(max_int(max_int(c_cmd_w, c_len_w),
                                             max_int(c_type_w, c_time_w)), c_bpc);
    localparam int c_cnt_w = $clog2(c_sr_w + 1);

    logic                cs_sync;
    logic                mosi_sync;
    logic                bit_strobe;

    state_t              state;
    logic [c_cnt_w-1:0]  bit_cnt;
    logic [c_sr_w-2:0]   sr;
    logic [c_sr_w-1:0]   sr_next;
    logic [c_cmd_w-1:0]  cmd_q;
    logic [c_len_w-1:0]  byte_cnt;
    logic [c_len_w-1:0]  len_next;
    logic [2:0]          bit8;
    logic [c_type_w-1:0] type_q;
    // One bit wider than o_addr so the "buffer full" value is representable
    logic [c_addr_w:0]   addr_cnt;
    logic                dropped;
    logic                in_payload;
    logic                in_kf;

    serial_sync u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_dck      (i_dck),
        .i_cs       (i_cs),
        .i_mosi     (i_mosi),
        .cs         (cs_sync),
        .mosi       (mosi_sync),
        .bit_strobe (bit_strobe)
    );

    assign sr_next     = {sr, mosi_sync};
    assign len_next    = sr_next[c_len_w-1:0];
    assign in_kf       = (state == S_KF_TYPE) || (state == S_KF_DUR) || (state == S_KF_DATA);
    assign in_payload  = in_kf || (state == S_SKIP);
    assign o_addr      = addr_cnt[c_addr_w-1:0];
    assign o_dbg_state = state;

    // Message FSM: field counting, header latching, word writes and payload length tracking
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_CMD;
            bit_cnt   <= '0;
            sr        <= '0;
            cmd_q     <= '0;
            byte_cnt  <= '0;
            bit8      <= 3'd0;
            type_q    <= '0;
            addr_cnt  <= '0;
            dropped   <= 1'b0;
            o_wen     <= 1'b0;
            o_data    <= '0;
            o_time    <= '0;
            o_type    <= '0;
            o_kf_done <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_wen     <= 1'b0;
            o_kf_done <= 1'b0;
            o_err     <= 1'b0;

            // Address advances in the cycle after each write strobe
            if (o_wen) begin
                addr_cnt <= addr_cnt + (c_addr_w + 1)'(1);
            end

            if (cs_sync) begin
                // Deselect abandons any message in flight; a strobe this cycle is ignored
                state    <= S_CMD;
                bit_cnt  <= '0;
                bit8     <= 3'd0;
                byte_cnt <= '0;
                if (!(state == S_CMD && bit_cnt == '0)) begin
                    o_err <= 1'b1;
                end
            end else if (bit_strobe) begin
                sr <= sr_next[c_sr_w-2:0];

                case (state)
                    S_CMD: begin
                        if (bit_cnt == c_cnt_w'(c_cmd_w - 1)) begin
                            cmd_q   <= sr_next[c_cmd_w-1:0];
                            bit_cnt <= '0;
                            state   <= S_LEN;
                        end else begin
                            bit_cnt <= bit_cnt + c_cnt_w'(1);
                        end
                    end
                    S_LEN: begin
                        if (bit_cnt == c_cnt_w'(c_len_w - 1)) begin
                            bit_cnt  <= '0;
                            byte_cnt <= len_next;
                            bit8     <= 3'd0;
                            if (len_next == '0) begin
                                state <= S_CMD;
                            end else if (cmd_q == c_cmd_w'(CMD_KEYFRAME)) begin
                                if (len_next >= c_len_w'(2)) begin
                                    state <= S_KF_TYPE;
                                end else begin
                                    // Too short to hold the keyframe header
                                    state <= S_SKIP;
                                    o_err <= 1'b1;
                                end
                            end else begin
                                state <= S_SKIP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + c_cnt_w'(1);
                        end
                    end
                    S_KF_TYPE: begin
                        if (bit_cnt == c_cnt_w'(c_type_w - 1)) begin
                            type_q  <= sr_next[c_type_w-1:0];
                            bit_cnt <= '0;
                            state   <= S_KF_DUR;
                        end else begin
                            bit_cnt <= bit_cnt + c_cnt_w'(1);
                        end
                    end
                    S_KF_DUR: begin
                        if (bit_cnt == c_cnt_w'(c_time_w - 1)) begin
                            // Type and duration become visible together
                            o_type   <= type_q;
                            o_time   <= sr_next[c_time_w-1:0];
                            addr_cnt <= '0;
                            dropped  <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= S_KF_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + c_cnt_w'(1);
                        end
                    end
                    S_KF_DATA: begin
                        if (bit_cnt == c_cnt_w'(c_bpc - 1)) begin
                            bit_cnt <= '0;
                            if (addr_cnt < (c_addr_w + 1)'(c_channels)) begin
                                o_wen  <= 1'b1;
                                o_data <= sr_next[c_bpc-1:0];
                            end else if (!dropped) begin
                                // Report overflow once per message
                                o_err   <= 1'b1;
                                dropped <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + c_cnt_w'(1);
                        end
                    end
                    S_SKIP: begin
                    end
                    default: begin
                        state <= S_CMD;
                    end
                endcase

                // Payload length governs when a message ends, whatever state it is in;
                // an incomplete trailing word is simply abandoned here
                if (in_payload) begin
                    bit8 <= bit8 + 3'd1;
                    if (bit8 == 3'd7) begin
                        byte_cnt <= byte_cnt - c_len_w'(1);
                        if (byte_cnt == c_len_w'(1)) begin
                            if (in_kf) begin
                                o_kf_done <= 1'b1;
                            end
                            state   <= S_CMD;
                            bit_cnt <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_decoder.sv
// Bench for frame_decoder (one LED board, 32 channels). Frames are built
// as bit lists, a message-level model derives the expected writes,
// errors and keyframe completions, and one compare process checks every
// output pulse against those expectations.
module tb_frame_decoder;

    import protocol_pkg::*;

    localparam int CH   = 32;
    localparam int BPC  = 12;
    localparam int AW   = 5;
    localparam int TW   = 10;
    localparam int YW   = 6;

    logic          clk;
    logic          i_rst;
    logic          i_dck;
    logic          i_cs;
    logic          i_mosi;
    logic          o_wen;
    logic [AW-1:0] o_addr;
    logic [BPC-1:0] o_data;
    logic [TW-1:0] o_time;
    logic [YW-1:0] o_type;
    logic          o_kf_done;
    logic          o_err;
    state_t        dbg_state;

    frame_decoder #(
        .c_ledboards (1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_dck       (i_dck),
        .i_cs        (i_cs),
        .i_mosi      (i_mosi),
        .o_wen       (o_wen),
        .o_addr      (o_addr),
        .o_data      (o_data),
        .o_time      (o_time),
        .o_type      (o_type),
        .o_kf_done   (o_kf_done),
        .o_err       (o_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, got >90000 cycles required <90000");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [AW+BPC-1:0] exp_q[$];   // {addr, data} of each expected write
    logic [TW+YW-1:0]  kf_q[$];    // {time, type} at each expected kf_done
    int                exp_err_pending = 0;
    logic [TW-1:0]     exp_time = '0;
    logic [YW-1:0]     exp_type = '0;

    int obs_wen = 0;
    int obs_err = 0;
    int obs_kf  = 0;

    bit          frame_bits[$];
    logic [11:0] kf_words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame building ----------------
    function automatic void push_field(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) frame_bits.push_back(v[i]);
    endfunction

    function automatic void add_kf(input int len, input logic [5:0] typ, input logic [9:0] dur);
        bit p[$];
        push_field(0, 5);
        push_field(len, 11);
        for (int i = 5; i >= 0; i--) p.push_back(typ[i]);
        for (int i = 9; i >= 0; i--) p.push_back(dur[i]);
        foreach (kf_words[k])
            for (int b = 11; b >= 0; b--) p.push_back(kf_words[k][b]);
        while (p.size() < 8 * len) p.push_back(1'b0);
        while (p.size() > 8 * len) void'(p.pop_back());
        foreach (p[i]) frame_bits.push_back(p[i]);
    endfunction

    function automatic void add_other(input int cmd, input int len);
        push_field(cmd, 5);
        push_field(len, 11);
        for (int i = 0; i < 8 * len; i++) frame_bits.push_back(bit'($urandom_range(0, 1)));
    endfunction

    function automatic logic [31:0] get_bits(input int pos, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r = {r[30:0], frame_bits[pos + i]};
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // Walks the bits of one CS window message by message. A window that
    // ends partway through a message is an abort.
    function automatic void model_frame();
        int n, pos, cmd, len, plen, got, nw;
        bit dropped;
        n   = frame_bits.size();
        pos = 0;
        while (pos < n) begin
            if (n - pos < 16) begin
                exp_err_pending++;
                return;
            end
            cmd = int'(get_bits(pos, 5));
            len = int'(get_bits(pos + 5, 11));
            pos += 16;
            if (len == 0) continue;
            plen = 8 * len;
            got  = n - pos;
            if (got > plen) got = plen;
            if (cmd == 0 && len < 2) begin
                exp_err_pending++;
            end else if (cmd == 0 && got >= 16) begin
                exp_type = YW'(get_bits(pos, 6));
                exp_time = TW'(get_bits(pos + 6, 10));
                nw = (plen - 16) / 12;
                dropped = 1'b0;
                for (int k = 0; k < nw; k++) begin
                    if (16 + 12 * (k + 1) > got) break;
                    if (k < CH) exp_q.push_back({AW'(k), BPC'(get_bits(pos + 16 + 12 * k, 12))});
                    else if (!dropped) begin
                        exp_err_pending++;
                        dropped = 1'b1;
                    end
                end
            end
            if (got < plen) begin
                exp_err_pending++;
                return;
            end
            if (cmd == 0 && len >= 2) kf_q.push_back({exp_time, exp_type});
            pos += plen;
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [AW+BPC-1:0] e;
        logic [TW+YW-1:0]  k;
        if (!i_rst) begin
            if (o_wen === 1'b1) begin
                obs_wen++;
                if (exp_q.size() == 0) check("wen_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("wen_addr", o_addr, e[AW+BPC-1:BPC]);
                    check("wen_data", o_data, e[BPC-1:0]);
                end
            end
            if (o_err === 1'b1) begin
                obs_err++;
                check("err_expected", exp_err_pending > 0, 1);
                if (exp_err_pending > 0) exp_err_pending--;
            end
            if (o_kf_done === 1'b1) begin
                obs_kf++;
                if (kf_q.size() == 0) check("kf_unexpected", 1, 0);
                else begin
                    k = kf_q.pop_front();
                    check("kf_time", o_time, k[TW+YW-1:YW]);
                    check("kf_type", o_type, k[YW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end on a falling clock edge
    task automatic send_bit(input bit b);
        i_mosi = b;
        i_dck  = 1'b0;
        repeat (4) @(negedge clk);
        i_dck  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_low();
        i_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk);
        i_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame_bits();
        foreach (frame_bits[i]) send_bit(frame_bits[i]);
    endtask

    task automatic run_frame();
        model_frame();
        cs_low();
        send_frame_bits();
        cs_high();
    endtask

    task automatic scen_check(input string name);
        check({name, "_wen_left"}, exp_q.size(), 0);
        check({name, "_err_left"}, exp_err_pending, 0);
        check({name, "_kf_left"}, kf_q.size(), 0);
        check({name, "_time"}, o_time, exp_time);
        check({name, "_type"}, o_type, exp_type);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0, e0, k0, nm, cut;
        i_rst  = 1'b0;
        i_cs   = 1'b1;
        i_dck  = 1'b0;
        i_mosi = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("rst_wen", o_wen, 0);
        check("rst_addr", o_addr, 0);
        check("rst_data", o_data, 0);
        check("rst_time", o_time, 0);
        check("rst_type", o_type, 0);
        check("rst_kf_done", o_kf_done, 0);
        check("rst_err", o_err, 0);
        check("rst_state", dbg_state, S_CMD);
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        repeat (4) @(negedge clk);

        // Full keyframe: 32 words 0..31
        w0 = obs_wen; e0 = obs_err; k0 = obs_kf;
        frame_bits.delete();
        kf_words.delete();
        for (int i = 0; i < 32; i++) kf_words.push_back(12'(i));
        add_kf(50, 6'h2A, 10'h155);
        run_frame();
        check("t1_wen_count", obs_wen - w0, 32);
        check("t1_kf_count", obs_kf - k0, 1);
        check("t1_err_count", obs_err - e0, 0);
        check("t1_time", o_time, 10'h155);
        check("t1_type", o_type, 6'h2A);
        scen_check("t1");

        // Unknown command skipped, then keyframe in the same window
        w0 = obs_wen; e0 = obs_err; k0 = obs_kf;
        frame_bits.delete();
        kf_words.delete();
        add_other(3, 4);
        add_kf(2, 6'h3C, 10'h001);
        run_frame();
        check("t2_wen_count", obs_wen - w0, 0);
        check("t2_kf_count", obs_kf - k0, 1);
        check("t2_err_count", obs_err - e0, 0);
        check("t2_time", o_time, 10'h001);
        check("t2_type", o_type, 6'h3C);
        scen_check("t2");

        // Overflow: 34 words into 32 channels
        w0 = obs_wen; e0 = obs_err; k0 = obs_kf;
        frame_bits.delete();
        kf_words.delete();
        for (int i = 0; i < 34; i++) kf_words.push_back(12'($urandom_range(0, 4095)));
        add_kf(65, 6'h01, 10'h0C3);
        run_frame();
        check("t3_wen_count", obs_wen - w0, 32);
        check("t3_err_count", obs_err - e0, 1);
        check("t3_kf_count", obs_kf - k0, 1);
        scen_check("t3");

        // CS abort after 7 data bits, then a clean keyframe
        w0 = obs_wen; e0 = obs_err; k0 = obs_kf;
        frame_bits.delete();
        kf_words.delete();
        for (int i = 0; i < 8; i++) kf_words.push_back(12'hFFF);
        add_kf(20, 6'h11, 10'h0F0);
        while (frame_bits.size() > 16 + 16 + 7) void'(frame_bits.pop_back());
        run_frame();
        check("t4_abort_err", obs_err - e0, 1);
        check("t4_abort_wen", obs_wen - w0, 0);
        check("t4_abort_kf", obs_kf - k0, 0);
        scen_check("t4a");
        w0 = obs_wen;
        frame_bits.delete();
        kf_words.delete();
        kf_words.push_back(12'h123);
        kf_words.push_back(12'h456);
        kf_words.push_back(12'h789);
        kf_words.push_back(12'hABC);
        add_kf(8, 6'h07, 10'h3FF);
        run_frame();
        check("t4_clean_wen", obs_wen - w0, 4);
        check("t4_clean_time", o_time, 10'h3FF);
        scen_check("t4b");

        // Keyframe with L=1: rejected, header outputs untouched
        w0 = obs_wen; e0 = obs_err; k0 = obs_kf;
        frame_bits.delete();
        kf_words.delete();
        add_kf(1, 6'h22, 10'h111);
        run_frame();
        check("t5_err_count", obs_err - e0, 1);
        check("t5_kf_count", obs_kf - k0, 0);
        check("t5_wen_count", obs_wen - w0, 0);
        check("t5_time", o_time, 10'h3FF);
        check("t5_type", o_type, 6'h07);
        scen_check("t5");

        // Randomised windows: mixed commands, lengths, occasional aborts
        for (int f = 0; f < 6; f++) begin
            frame_bits.delete();
            nm = $urandom_range(1, 3);
            for (int m = 0; m < nm; m++) begin
                if ($urandom_range(0, 3) != 0) begin
                    kf_words.delete();
                    for (int i = 0; i < 12; i++) kf_words.push_back(12'($urandom_range(0, 4095)));
                    add_kf($urandom_range(0, 16), 6'($urandom_range(0, 63)), 10'($urandom_range(0, 1023)));
                end else begin
                    add_other($urandom_range(1, 31), $urandom_range(0, 6));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                cut = $urandom_range(1, frame_bits.size() - 1);
                while (frame_bits.size() > cut) void'(frame_bits.pop_back());
            end
            run_frame();
            scen_check("rnd");
        end

        // Reset in the middle of keyframe data
        frame_bits.delete();
        kf_words.delete();
        for (int i = 0; i < 18; i++) kf_words.push_back(12'(12'h100 + i));
        add_kf(30, 6'h15, 10'h2AA);
        while (frame_bits.size() > 16 + 16 + 12 * 5 + 4) void'(frame_bits.pop_back());
        w0 = obs_wen;
        model_frame();
        cs_low();
        send_frame_bits();
        repeat (3) @(negedge clk);
        check("t6_wen_before_rst", obs_wen - w0, 5);
        #2 i_rst = 1'b1;
        #1;
        exp_q.delete();
        kf_q.delete();
        exp_err_pending = 0;
        exp_time = '0;
        exp_type = '0;
        check("t6_rst_wen", o_wen, 0);
        check("t6_rst_addr", o_addr, 0);
        check("t6_rst_data", o_data, 0);
        check("t6_rst_time", o_time, 0);
        check("t6_rst_type", o_type, 0);
        check("t6_rst_kf_done", o_kf_done, 0);
        check("t6_rst_err", o_err, 0);
        i_cs  = 1'b1;
        i_dck = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        repeat (6) @(negedge clk);
        w0 = obs_wen; k0 = obs_kf;
        frame_bits.delete();
        kf_words.delete();
        for (int i = 0; i < 4; i++) kf_words.push_back(12'($urandom_range(0, 4095)));
        add_kf(8, 6'h3E, 10'h204);
        run_frame();
        check("t6_post_wen", obs_wen - w0, 4);
        check("t6_post_kf", obs_kf - k0, 1);
        scen_check("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
